redundant_tx: RTL and testbench

Transmit-side counterpart of the five-copy redundant receiver. It buffers one frame from an upstream byte stream, then emits it R times back-to-back, separated by a fixed gap. In each copy it overwrites the low nibble of the byte at offset ID_POS with the copy index 1..R. It sits between the payload/framing logic and the MAC/PHY transmit path, so the receive side can store the copies and majority-vote on them.

---
 rtl/redundant_tx.sv | 171 +++++++++++++++++
 tb/tb_redundant_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/redundant_tx.sv
// Buffers one upstream frame and transmits it R times with a GAP-cycle gap, stamping the copy index into the ID byte.
// Optional REDUNDANT_TX_SEQ_EN: the ID byte high nibble carries a per-frame sequence counter instead of the stored nibble.
module redundant_tx #(
    parameter int unsigned R      = 5,
    parameter int unsigned ID_POS = 0,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned GAP    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_en,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       tx_en,
    output logic [7:0] txd,
    output logic [3:0] tx_copy,
    output logic       drop,
    output logic       overflow
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        rd_q;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] raddr;
    logic [3:0]        copy;
    logic [GW-1:0]     gcnt;
    logic              in_en_q;
    logic              rej;
    logic              ovf_done;
    logic              rd_v;
    logic              rd_id;
    logic [3:0]        rd_copy;
    logic [3:0]        hi;
    logic              accept;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              last_addr;

`ifdef REDUNDANT_TX_SEQ_EN
    logic [3:0] seq;
    logic [3:0] rd_hi;
    assign hi = rd_hi;
`else
    assign hi = rd_q[7:4];
`endif

    assign accept    = (state == S_IDLE) && in_en && !rej;
    assign we        = accept || ((state == S_LOAD) && in_en && (len != LEN_MAX));
    assign waddr     = accept ? '0 : len[ADDR_W-1:0];
    assign last_addr = ({1'b0, raddr} == (len - 1'b1));

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= in_data;
        rd_q <= mem[raddr];
    end

    // Two-stage read pipeline (address issue, then registered output) runs alongside the FSM;
    // busy is held until the pipeline has drained after the last copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            len      <= '0;
            raddr    <= '0;
            copy     <= '0;
            gcnt     <= '0;
            in_en_q  <= 1'b0;
            rej      <= 1'b0;
            ovf_done <= 1'b0;
            rd_v     <= 1'b0;
            rd_id    <= 1'b0;
            rd_copy  <= '0;
            busy     <= 1'b0;
            tx_en    <= 1'b0;
            txd      <= '0;
            tx_copy  <= '0;
            drop     <= 1'b0;
            overflow <= 1'b0;
`ifdef REDUNDANT_TX_SEQ_EN
            seq      <= '0;
            rd_hi    <= '0;
`endif
        end else begin
            drop     <= 1'b0;
            overflow <= 1'b0;
            in_en_q  <= in_en;
            if (!in_en)
                rej <= 1'b0;

            tx_en   <= rd_v;
            tx_copy <= rd_v ? rd_copy : '0;
            txd     <= !rd_v ? '0 : (rd_id ? {hi, rd_copy} : rd_q);
            rd_v    <= 1'b0;
            rd_id   <= 1'b0;
            rd_copy <= '0;

            case (state)
                S_IDLE: begin
                    busy <= rd_v;
                    if (accept) begin
                        len      <= (ADDR_W+1)'(1);
                        ovf_done <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_en) begin
                        if (len == LEN_MAX) begin
                            if (!ovf_done) begin
                                overflow <= 1'b1;
                                ovf_done <= 1'b1;
                            end
                        end else begin
                            len <= len + 1'b1;
                        end
                    end else if (32'(len) <= ID_POS) begin
                        drop  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        copy  <= 4'd1;
                        raddr <= '0;
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    rd_v    <= 1'b1;
                    rd_id   <= (32'(raddr) == ID_POS);
                    rd_copy <= copy;
`ifdef REDUNDANT_TX_SEQ_EN
                    rd_hi   <= seq;
`endif
                    raddr   <= raddr + 1'b1;
                    if (last_addr) begin
                        if (copy == 4'(R)) begin
                            state <= S_IDLE;
`ifdef REDUNDANT_TX_SEQ_EN
                            seq   <= seq + 1'b1;
`endif
                        end else begin
                            gcnt  <= '0;
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gcnt == GW'(GAP - 1)) begin
                        copy  <= copy + 1'b1;
                        raddr <= '0;
                        state <= S_SEND;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (((state == S_SEND) || (state == S_GAP)) && in_en && !in_en_q) begin
                drop <= 1'b1;
                rej  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_redundant_tx.sv
// Scoreboard bench for redundant_tx: the driver predicts every output byte, pulse and busy edge by cycle number,
// and an independent negedge monitor pops and compares them as the DUT produces them.
module tb_redundant_tx;
    localparam int unsigned R      = 5;
    localparam int unsigned ID_POS = 3;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned GAP    = 12;
    localparam int DEPTH = 1 << ADDR_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       busy, tx_en, drop, overflow;
    logic [7:0] txd;
    logic [3:0] tx_copy;

    redundant_tx #(.R(R), .ID_POS(ID_POS), .ADDR_W(ADDR_W), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_data(in_data),
        .busy(busy), .tx_en(tx_en), .txd(txd), .tx_copy(tx_copy),
        .drop(drop), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    function void chk(string name, int act, int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endfunction

    typedef struct {
        logic [7:0] d;
        logic [3:0] c;
        int         t;
    } item_t;

    item_t exp_q[$];
    int    drop_q[$];
    int    ovf_q[$];
    int    rise_q[$];
    int    fall_q[$];

    logic [7:0] fb [0:127];
    int         idle_at = 0;
    int         last_N = 0;
    bit         last_tx = 1'b0;
    logic [3:0] seq_m = 4'd0;

    // Monitor: everything the DUT shows is checked against the queued predictions.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        item_t e;
        if (tx_en) begin
            if (exp_q.size() == 0) chk("tx_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("txd", int'(txd), int'(e.d));
                chk("tx_copy", int'(tx_copy), int'(e.c));
                chk("tx_cycle", cyc, e.t);
            end
        end else begin
            chk("tx_copy_idle", int'(tx_copy), 0);
        end
        if (drop) begin
            if (drop_q.size() == 0) chk("drop_unexpected", 1, 0);
            else chk("drop_cycle", cyc, drop_q.pop_front());
        end
        if (overflow) begin
            if (ovf_q.size() == 0) chk("overflow_unexpected", 1, 0);
            else chk("overflow_cycle", cyc, ovf_q.pop_front());
        end
        if (busy && !busy_prev) begin
            if (rise_q.size() == 0) chk("busy_rise_unexpected", 1, 0);
            else chk("busy_rise_cycle", cyc, rise_q.pop_front());
        end
        if (!busy && busy_prev) begin
            if (fall_q.size() == 0) chk("busy_fall_unexpected", 1, 0);
            else chk("busy_fall_cycle", cyc, fall_q.pop_front());
        end
        busy_prev = busy;
    end

    // Reference model: a frame first sampled at edge s with n bytes ends at edge N = s + n.
    // Copy k byte j appears after edge N + 2 + (k-1)(len+GAP) + j; busy falls at N + R*len + (R-1)*GAP + 2.
    task automatic send_frame(input int n);
        int s, N, len;
        logic [3:0] hi;
        item_t e;
        @(negedge clk);
        s = cyc + 1;
        N = s + n;
        len = (n > DEPTH) ? DEPTH : n;
        last_tx = 1'b0;
        if (s < idle_at) begin
            drop_q.push_back(s);
        end else begin
            rise_q.push_back(s);
            if (n > DEPTH) ovf_q.push_back(s + DEPTH);
            if (len <= int'(ID_POS)) begin
                drop_q.push_back(N);
                fall_q.push_back(N);
                idle_at = N + 1;
            end else begin
`ifdef REDUNDANT_TX_SEQ_EN
                hi = seq_m;
`else
                hi = fb[ID_POS][7:4];
`endif
                for (int k = 1; k <= int'(R); k++) begin
                    for (int j = 0; j < len; j++) begin
                        e.d = (j == int'(ID_POS)) ? {hi, 4'(k)} : fb[j];
                        e.c = 4'(k);
                        e.t = N + 2 + (k - 1) * (len + int'(GAP)) + j;
                        exp_q.push_back(e);
                    end
                end
                idle_at = N + int'(R) * len + (int'(R) - 1) * int'(GAP) + 2;
                fall_q.push_back(idle_at);
                seq_m = seq_m + 4'd1;
                last_tx = 1'b1;
            end
        end
        for (int i = 0; i < n; i++) begin
            in_en = 1'b1;
            in_data = fb[i];
            @(negedge clk);
        end
        in_en = 1'b0;
        in_data = 8'($urandom);
        last_N = N;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < idle_at) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r, n;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_tx_en", int'(tx_en), 0);
        chk("reset_txd", int'(txd), 0);
        chk("reset_tx_copy", int'(tx_copy), 0);
        chk("reset_drop", int'(drop), 0);
        chk("reset_overflow", int'(overflow), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame filling the buffer exactly.
        for (int i = 0; i < DEPTH; i++) fb[i] = 8'(i);
        fb[ID_POS] = 8'hA0;
        send_frame(DEPTH);
        wait_idle();

        // Too short (len <= ID_POS), then the shortest accepted frame (ID byte last).
        fill_random(8);
        send_frame(int'(ID_POS));
        wait_idle();
        send_frame(1);
        wait_idle();
        fill_random(8);
        send_frame(int'(ID_POS) + 1);
        wait_idle();

        // Second frame arriving during copy 3 is rejected; next frame goes through.
        fill_random(40);
        send_frame(40);
        wait_until(last_N + 2 + 2 * (40 + int'(GAP)) + 5);
        fill_random(6);
        send_frame(6);
        wait_idle();
        fill_random(30);
        send_frame(30);
        wait_idle();

        // Rejected frame still running when the block returns to idle stays ignored.
        fill_random(10);
        send_frame(10);
        wait_until(idle_at - 7);
        fill_random(12);
        send_frame(12);
        fill_random(9);
        wait_idle();
        send_frame(9);
        wait_idle();

        // Overflow.
        fill_random(DEPTH + 6);
        send_frame(DEPTH + 6);
        wait_idle();

        // Three frames with ID byte F0.
        for (int f = 0; f < 3; f++) begin
            fill_random(8);
            fb[ID_POS] = 8'hF0;
            wait_idle();
            send_frame(8);
        end
        wait_idle();

        // Reset during copy 2.
        fill_random(20);
        send_frame(20);
        wait_until(last_N + 2 + 20 + int'(GAP) + 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        r = cyc;
        exp_q.delete();
        fall_q.delete();
        fall_q.push_back(r);
        seq_m = 4'd0;
        idle_at = r + 1;
        @(negedge clk);
        rst = 1'b0;
        chk("after_rst_tx_en", int'(tx_en), 0);
        chk("after_rst_busy", int'(busy), 0);
        fill_random(12);
        fb[ID_POS] = 8'hF0;
        wait_idle();
        send_frame(12);
        wait_idle();

        // Randomized frames with occasional mid-transmission rejects.
        for (int it = 0; it < 12; it++) begin
            n = int'($urandom_range(1, DEPTH + 6));
            fill_random(n);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame(n);
            if (last_tx && ($urandom_range(0, 2) == 0)) begin
                wait_until(int'($urandom_range(last_N + 1, idle_at - 5)));
                n = int'($urandom_range(1, 15));
                fill_random(n);
                send_frame(n);
            end
        end

        wait_idle();
        wait_until(idle_at + 10);
        chk("pending_tx_bytes", exp_q.size(), 0);
        chk("pending_drops", drop_q.size(), 0);
        chk("pending_overflows", ovf_q.size(), 0);
        chk("pending_busy_rises", rise_q.size(), 0);
        chk("pending_busy_falls", fall_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
